seq_divider16: RTL and testbench

- Sequential unsigned integer divider: quotient = dividend / divisor, remainder = dividend % divisor.
- Inverse operation to the combinational 16x16 array multiplier in the ALU datapath.
- Restoring algorithm, one quotient bit per clock, WIDTH iterations.
- start/busy/done handshake toward the ALU control sequencer.

---
 rtl/seq_divider16_if.sv | 24 ++
 rtl/seq_divider16.sv | 96 +++++++++
 tb/tb_seq_divider16.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider16_if.sv
// Start/busy/done handshake and operand/result bus of the
// sequential unsigned divider.
interface seq_divider16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider16.sv
// Restoring unsigned divider, one quotient bit per clock,
// WIDTH iterations per operation.
module seq_divider16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_divider16_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;

  logic [WIDTH:0]   sh_d;
  logic [WIDTH:0]   t_d;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;

  // Partial remainder stays below D, so only the shifted value
  // and the trial difference need the extra MSB.
  always_comb begin
    sh_d = {r_q, q_q[WIDTH-1]};
    t_d  = sh_d - {1'b0, d_q};
    r_d  = sh_d[WIDTH-1:0];
    q_d  = {q_q[WIDTH-2:0], 1'b0};
    if (!t_d[WIDTH]) begin
      r_d = t_d[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              q_q     <= bus.dividend;
              r_q     <= '0;
              d_q     <= bus.divisor;
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              quo_q   <= '1;
              rem_q   <= bus.dividend;
              dz_q    <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quo_q   <= q_d;
            rem_q   <= r_d;
            dz_q    <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Randomised bench for seq_divider16 against an arithmetic
// model of operation timing and results.
module tb_seq_divider16;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_divider16_if #(.WIDTH(W)) bus ();

  seq_divider16 #(.WIDTH(W), .CNT_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: counts cycles to the done pulse, results from / and %.
  int          left = 0;
  bit          mdone = 1'b0;
  bit          hdz = 1'b0;
  logic [15:0] hq = '0, hr = '0;
  logic [15:0] eq = '0, er = '0;
  logic [15:0] oa = '0, ob = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left  <= 0;
      mdone <= 1'b0;
      hdz   <= 1'b0;
      hq    <= '0;
      hr    <= '0;
    end else if (mdone) begin
      mdone <= 1'b0;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 1) begin
        mdone <= 1'b1;
        hq    <= eq;
        hr    <= er;
        hdz   <= 1'b0;
      end
    end else if (bus.start) begin
      oa <= bus.dividend;
      ob <= bus.divisor;
      if (bus.divisor == 16'd0) begin
        mdone <= 1'b1;
        hq    <= 16'hFFFF;
        hr    <= bus.dividend;
        hdz   <= 1'b1;
      end else begin
        left <= W;
        eq   <= bus.dividend / bus.divisor;
        er   <= bus.dividend % bus.divisor;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(bus.busy), 32'(left > 0));
      chk("done", 32'(bus.done), 32'(mdone));
      chk("quotient", 32'(bus.quotient), 32'(hq));
      chk("remainder", 32'(bus.remainder), 32'(hr));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(hdz));
      if (bus.done && !bus.div_by_zero) begin
        chk("q*d+r", 32'(bus.quotient) * 32'(ob) + 32'(bus.remainder),
            32'(oa));
        chk("r<d", 32'(bus.remainder < ob), 32'd1);
      end
    end
  end

  task automatic op(input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] xq, input logic [15:0] xr,
                    input bit xdz, input string nm);
    int n;
    int bcnt;
    bit got;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 16'($urandom);
    n = 1;
    bcnt = 0;
    got = 1'b0;
    while (n <= 40) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, "_latency"}, 32'(n), (b == 16'd0) ? 32'd1 : 32'd17);
      chk({nm, "_busycyc"}, 32'(bcnt), (b == 16'd0) ? 32'd0 : 32'd16);
      chk({nm, "_q"}, 32'(bus.quotient), 32'(xq));
      chk({nm, "_r"}, 32'(bus.remainder), 32'(xr));
      chk({nm, "_dz"}, 32'(bus.div_by_zero), 32'(xdz));
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    int t1;
    int t2;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);

    op(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, "basic");
    op(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, "div1");
    op(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, "same");
    op(16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, "msb");
    op(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, "small");
    op(16'd0, 16'd3, 16'd0, 16'd0, 1'b0, "zero");
    op(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, "dz");
    op(16'd10, 16'd3, 16'd3, 16'd1, 1'b0, "afterdz");

    // Abort mid-operation: reset must clear results at once.
    @(negedge clk);
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_q", 32'(bus.quotient), 32'd0);
    chk("abort_r", 32'(bus.remainder), 32'd0);
    chk("abort_dz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("abort_nodone", 32'(dn), 32'd0);
    op(16'd100, 16'd9, 16'd11, 16'd1, 1'b0, "postrst");

    // Start held high with operands changing every cycle.
    @(negedge clk);
    bus.start = 1'b1;
    dn = 0;
    t1 = 0;
    t2 = 0;
    for (int i = 0; i < 40; i++) begin
      bus.dividend = 16'($urandom);
      bus.divisor  = 16'($urandom_range(1, 65535));
      @(negedge clk);
      if (bus.done) begin
        if (dn == 0) t1 = i;
        else t2 = i;
        dn++;
      end
    end
    bus.start = 1'b0;
    chk("hs_count", 32'(dn), 32'd2);
    chk("hs_gap", 32'(t2 - t1), 32'd18);
    repeat (25) @(negedge clk);

    for (int c = 0; c < 45000; c++) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 3) != 0);
      bus.dividend = 16'($urandom);
      case ($urandom_range(0, 3))
        0: bus.divisor = 16'($urandom_range(1, 15));
        1: bus.divisor = 16'($urandom);
        2: bus.divisor = 16'($urandom) | 16'h8000;
        default: bus.divisor = 16'($urandom) >> $urandom_range(0, 15);
      endcase
      if (bus.divisor == 16'd0) bus.divisor = 16'd1;
    end
    bus.start = 1'b0;
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
